// File: rtl/pipe_stage_latch_pkg.sv
// Shared types for the generic pipeline stage latch: occupancy state and NOP defaults.
package pipe_stage_latch_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } latch_state_t;

   localparam logic [31:0] NOP_W32 = 32'h0;

   // Occupancy follows directly from the two slot valid bits; skid is only ever filled behind a head.
   function automatic latch_state_t state_of(input logic head_v, input logic skid_v);
      if (skid_v) return FULL;
      if (head_v) return ONE;
      return EMPTY;
   endfunction

endpackage

// File: rtl/pipe_stage_latch_slot.sv
// One storage entry of the stage latch: WIDTH-bit data register plus valid, clear beats load.
module pipe_stage_latch_slot #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             load,
   input  logic             clear,
   input  logic [WIDTH-1:0] d,
   output logic             valid,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         q     <= d;
      end
   end

endmodule

// File: rtl/pipe_stage_latch.sv
// Parametrised pipeline register with valid/ready, sync flush, optional skid entry and bubble counter.
module pipe_stage_latch
   import pipe_stage_latch_pkg::*;
#(
   parameter int               WIDTH  = 32,
   parameter int               SKID   = 0,
   parameter logic [WIDTH-1:0] BUBBLE = '0,
   parameter int               CNT_W  = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count,
   output logic [CNT_W-1:0] bubble_cnt
);

   logic             accept, consume;
   logic             head_v, head_load, head_clr;
   logic [WIDTH-1:0] head_q, head_din;

   assign accept  = in_valid & in_ready;
   assign consume = head_v & out_ready;

   pipe_stage_latch_slot #(.WIDTH(WIDTH)) u_head (
      .CLK   (CLK),
      .nRST  (nRST),
      .load  (head_load),
      .clear (head_clr),
      .d     (head_din),
      .valid (head_v),
      .q     (head_q)
   );

   generate
      if (SKID == 0) begin : g_single
         // Accept while full and consumed replaces the entry in place.
         assign in_ready  = !flush & (!head_v | out_ready);
         assign head_load = accept;
         assign head_clr  = flush | (consume & !accept);
         assign head_din  = in_data;
         assign count     = {1'b0, head_v};
      end else begin : g_skid
         logic             skid_v, skid_load, skid_clr, ready_q;
         logic [WIDTH-1:0] skid_q;

         // in_ready is registered and low only when FULL, so accept never coincides with skid_v.
         assign skid_load = !flush & accept & head_v & !consume;
         assign skid_clr  = flush | consume;
         assign head_load = (accept & (!head_v | consume)) | (skid_v & consume);
         assign head_din  = skid_v ? skid_q : in_data;
         assign head_clr  = flush | (consume & !accept & !skid_v);

         pipe_stage_latch_slot #(.WIDTH(WIDTH)) u_skid (
            .CLK   (CLK),
            .nRST  (nRST),
            .load  (skid_load),
            .clear (skid_clr),
            .d     (in_data),
            .valid (skid_v),
            .q     (skid_q)
         );

         always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) ready_q <= 1'b0;
            else       ready_q <= flush | !(skid_load | (skid_v & !skid_clr));
         end

         assign in_ready = ready_q;
         assign count    = 2'(state_of(head_v, skid_v));
      end
   endgenerate

   assign out_valid = head_v;
   assign out_data  = head_v ? head_q : BUBBLE;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)                               bubble_cnt <= '0;
      else if (!head_v && (bubble_cnt != '1))  bubble_cnt <= bubble_cnt + 1'b1;
   end

endmodule
